// File: rtl/gf180mcu_osu_sc_gp9t3v3__clkdiv_prog.sv
// Glitch-free programmable clock divider/inverter: registered divided clock
// with shadowed ratio/polarity, clean start/stop and a combinational N=1 bypass.
module gf180mcu_osu_sc_gp9t3v3__clkdiv_prog #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIV,
  input  logic             INV,
  output logic             Y,
  output logic             TC
);

  localparam int unsigned CW = WIDTH + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             inv_q, inv_d;
  logic             y_q, y_d;
  logic             tc_q, tc_d;

  logic [CW-1:0]    half_c;
  logic [CW-1:0]    cnt_inc_c;
  logic             last_c;
  logic             bypass_c;

  // High-phase length H = (N+1)>>1 with N = div_q+1; one extra bit avoids overflow at N=2^WIDTH.
  assign half_c    = (CW'(div_q) + CW'(2)) >> 1;
  assign cnt_inc_c = CW'(cnt_q) + CW'(1);
  assign last_c    = (cnt_q == div_q);
  assign bypass_c  = (state_q == ST_RUN) && (div_q == '0);

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      div_q   <= WIDTH'(1);
      inv_q   <= 1'b0;
      y_q     <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      inv_q   <= inv_d;
      y_q     <= y_d;
      tc_q    <= tc_d;
    end
  end

  // Ratio/polarity are only reloaded in IDLE or at a period boundary, so Y never runts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    inv_d   = inv_q;
    y_d     = y_q;
    tc_d    = 1'b0;

    if (state_q == ST_IDLE) begin
      div_d = DIV;
      inv_d = INV;
      cnt_d = '0;
      y_d   = INV;
      if (EN) begin
        state_d = ST_RUN;
        y_d     = ~INV;
        tc_d    = (DIV == '0);
      end
    end else if (last_c) begin
      div_d = DIV;
      inv_d = INV;
      cnt_d = '0;
      if (EN) begin
        y_d  = ~INV;
        tc_d = (DIV == '0);
      end else begin
        state_d = ST_IDLE;
        y_d     = INV;
      end
    end else begin
      cnt_d = cnt_inc_c[WIDTH-1:0];
      y_d   = (cnt_inc_c < half_c) ^ inv_q;
      tc_d  = (cnt_inc_c == CW'(div_q));
    end
  end

  // Bypass is only entered/left at a boundary, just after CLK rises, so the mux switch is clean.
  assign Y  = bypass_c ? (CLK ^ inv_q) : y_q;
  assign TC = tc_q;

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp9t3v3__clkdiv_prog.sv
// Self-checking bench for the programmable clock divider; expected Y/TC come
// from a period-queue model built from the ratio/polarity captured at each period start.
module tb_gf180mcu_osu_sc_gp9t3v3__clkdiv_prog;

  localparam int unsigned W = 4;

  logic         CLK;
  logic         RN;
  logic         EN;
  logic [W-1:0] DIV;
  logic         INV;
  logic         Y;
  logic         TC;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic y;
    logic tc;
  } ent_t;

  ent_t q[$];
  int   cur_n = 2;

  gf180mcu_osu_sc_gp9t3v3__clkdiv_prog #(.WIDTH(W)) dut (
    .CLK (CLK),
    .RN  (RN),
    .EN  (EN),
    .DIV (DIV),
    .INV (INV),
    .Y   (Y),
    .TC  (TC)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Drive inputs in the low phase, take one rising edge, and return the expected
  // Y in the high phase (eh), Y in the low phase (el) and TC for the new cycle.
  task automatic tick(input logic en, input logic [W-1:0] div, input logic inv,
                      output logic eh, output logic el, output logic et);
    ent_t e;
    int   n;
    int   h;
    EN  = en;
    DIV = div;
    INV = inv;
    @(posedge CLK);
    if (q.size() == 0 && en) begin
      n = int'(div) + 1;
      h = (n + 1) / 2;
      cur_n = n;
      for (int i = 0; i < n; i++) begin
        e.y  = (i < h) ? ~inv : inv;
        e.tc = (i == n - 1);
        q.push_back(e);
      end
    end
    if (q.size() == 0) begin
      eh = inv;
      el = inv;
      et = 1'b0;
    end else begin
      e  = q.pop_front();
      eh = e.y;
      et = e.tc;
      el = (cur_n == 1) ? ~e.y : e.y;
    end
    #2;
  endtask

  task automatic test_reset();
    logic eh, el, et;
    EN = 1'b0; DIV = '0; INV = 1'b0; RN = 1'b0;
    q.delete();
    #12;
    checks++; if (Y !== 1'b0) begin errors++; $display("FAIL reset_y got %b want 0", Y); end
    checks++; if (TC !== 1'b0) begin errors++; $display("FAIL reset_tc got %b want 0", TC); end
    @(negedge CLK); #1;
    RN = 1'b1;
    #1;
    for (int c = 0; c < 4; c++) begin
      tick(1'b0, W'($urandom), 1'b0, eh, el, et);
      checks++; if (Y !== eh || Y !== 1'b0) begin errors++; $display("FAIL idle_y cyc %0d got %b want 0", c, Y); end
      checks++; if (TC !== 1'b0) begin errors++; $display("FAIL idle_tc cyc %0d got %b want 0", c, TC); end
      @(negedge CLK); #2;
    end
  endtask

  task automatic test_div3();
    logic eh, el, et;
    logic [3:0] pat;
    pat = 4'b0011;
    for (int c = 0; c < 12; c++) begin
      tick(1'b1, W'(3), 1'b0, eh, el, et);
      checks++; if (Y !== eh || Y !== pat[c % 4]) begin errors++; $display("FAIL div3_y cyc %0d got %b want %b", c, Y, pat[c % 4]); end
      checks++; if (TC !== et || TC !== (c % 4 == 3)) begin errors++; $display("FAIL div3_tc cyc %0d got %b want %b", c, TC, et); end
      @(negedge CLK); #2;
      checks++; if (Y !== el) begin errors++; $display("FAIL div3_ylo cyc %0d got %b want %b", c, Y, el); end
    end
  endtask

  task automatic test_div4_inv();
    logic eh, el, et;
    int   highs;
    for (int pass = 0; pass < 2; pass++) begin
      highs = 0;
      for (int c = 0; c < 10; c++) begin
        tick(1'b1, W'(4), pass[0], eh, el, et);
        if (c >= 5) highs += int'(Y);
        checks++; if (Y !== eh) begin errors++; $display("FAIL div4_y pass %0d cyc %0d got %b want %b", pass, c, Y, eh); end
        checks++; if (TC !== et) begin errors++; $display("FAIL div4_tc pass %0d cyc %0d got %b want %b", pass, c, TC, et); end
        @(negedge CLK); #2;
      end
      checks++;
      if (highs != ((pass == 0) ? 3 : 2)) begin
        errors++; $display("FAIL div4_highs pass %0d got %0d want %0d", pass, highs, (pass == 0) ? 3 : 2);
      end
    end
  endtask

  task automatic test_div_change();
    logic eh, el, et;
    logic [W-1:0] d;
    // Let the inverted period drain, start fresh on DIV=3, then shrink to DIV=1 mid-period.
    while (q.size() != 0) begin
      tick(1'b1, W'(3), 1'b0, eh, el, et);
      @(negedge CLK); #2;
    end
    for (int c = 0; c < 12; c++) begin
      d = (c < 2) ? W'(3) : W'(1);
      tick(1'b1, d, 1'b0, eh, el, et);
      checks++; if (Y !== eh) begin errors++; $display("FAIL divchg_y cyc %0d got %b want %b", c, Y, eh); end
      checks++; if (TC !== et) begin errors++; $display("FAIL divchg_tc cyc %0d got %b want %b", c, TC, et); end
      @(negedge CLK); #2;
    end
  endtask

  task automatic test_en_drop();
    logic eh, el, et;
    for (int pass = 0; pass < 2; pass++) begin
      while (q.size() != 0) begin
        tick(1'b1, W'(7), pass[0], eh, el, et);
        @(negedge CLK); #2;
      end
      for (int c = 0; c < 14; c++) begin
        tick((c < 2), W'(7), pass[0], eh, el, et);
        checks++; if (Y !== eh) begin errors++; $display("FAIL endrop_y pass %0d cyc %0d got %b want %b", pass, c, Y, eh); end
        checks++; if (TC !== et) begin errors++; $display("FAIL endrop_tc pass %0d cyc %0d got %b want %b", pass, c, TC, et); end
        @(negedge CLK); #2;
      end
      checks++; if (Y !== pass[0] || TC !== 1'b0) begin errors++; $display("FAIL endrop_hold pass %0d got y=%b tc=%b", pass, Y, TC); end
    end
  endtask

  task automatic test_bypass();
    logic eh, el, et;
    for (int c = 0; c < 16; c++) begin
      tick((c < 12), '0, (c >= 6), eh, el, et);
      checks++; if (Y !== eh) begin errors++; $display("FAIL byp_yhi cyc %0d got %b want %b", c, Y, eh); end
      checks++; if (TC !== et) begin errors++; $display("FAIL byp_tc cyc %0d got %b want %b", c, TC, et); end
      @(negedge CLK); #2;
      checks++; if (Y !== el) begin errors++; $display("FAIL byp_ylo cyc %0d got %b want %b", c, Y, el); end
    end
  endtask

  task automatic test_reset_mid();
    logic eh, el, et;
    for (int c = 0; c < 3; c++) begin
      tick(1'b1, W'(5), 1'b0, eh, el, et);
      @(negedge CLK); #2;
    end
    RN = 1'b0;
    q.delete();
    #1;
    checks++; if (Y !== 1'b0) begin errors++; $display("FAIL rstmid_y got %b want 0", Y); end
    checks++; if (TC !== 1'b0) begin errors++; $display("FAIL rstmid_tc got %b want 0", TC); end
    @(negedge CLK); #1;
    RN = 1'b1;
    #1;
    for (int c = 0; c < 12; c++) begin
      tick(1'b1, W'(5), 1'b0, eh, el, et);
      checks++; if (Y !== eh || Y !== (c % 6 < 3)) begin errors++; $display("FAIL rstmid_run_y cyc %0d got %b want %b", c, Y, eh); end
      checks++; if (TC !== et || TC !== (c % 6 == 5)) begin errors++; $display("FAIL rstmid_run_tc cyc %0d got %b want %b", c, TC, et); end
      @(negedge CLK); #2;
    end
  endtask

  task automatic test_random();
    logic eh, el, et;
    logic en;
    for (int c = 0; c < 400; c++) begin
      en = ($urandom_range(0, 9) != 0);
      tick(en, W'($urandom), 1'($urandom), eh, el, et);
      checks++; if (Y !== eh) begin errors++; $display("FAIL rand_yhi cyc %0d got %b want %b", c, Y, eh); end
      checks++; if (TC !== et) begin errors++; $display("FAIL rand_tc cyc %0d got %b want %b", c, TC, et); end
      @(negedge CLK); #2;
      checks++; if (Y !== el) begin errors++; $display("FAIL rand_ylo cyc %0d got %b want %b", c, Y, el); end
    end
  endtask

  initial begin
    test_reset();
    test_div3();
    test_div4_inv();
    test_div_change();
    test_en_drop();
    test_bypass();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
